// File: rtl/fir_pkg.sv
// Shared constants, data types and small helpers for the FIR tap sequencer.
package fir_pkg;

  // Geometry of the filter: tap address, coefficient and ADC sample MSBs.
  localparam int ORDER_MSB  = 5;
  localparam int FILTER_MSB = 15;
  localparam int ADC_MSB    = 11;

  localparam int ORDER_W = ORDER_MSB + 1;
  localparam int COEF_W  = FILTER_MSB + 1;
  localparam int ADC_W   = ADC_MSB + 1;
  localparam int TAPS    = 2 ** ORDER_W;

  typedef logic signed [ADC_W-1:0]  sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic        [ORDER_W-1:0] tap_t;

  // CLEAR zeroes both memories after reset; RUN free-runs the tap index.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Next tap index; wraps TAPS-1 -> 0 through the natural tap_t width.
  function automatic tap_t tap_inc(input tap_t t);
    return t + tap_t'(1);
  endfunction

  // Circular offset (a - b) mod TAPS, used to walk back through the delay line.
  function automatic tap_t tap_sub(input tap_t a, input tap_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample handshake, coefficient write port and MAC-facing tap outputs.
interface fir_tap_sequencer_if;
  import fir_pkg::*;

  // Sample input handshake
  sample_t sample_in;
  logic    sample_valid;
  logic    sample_ready;

  // Coefficient load port
  logic    coef_we;
  tap_t    coef_waddr;
  coef_t   coef_wdata;

  // Outputs towards the multiply-accumulate stage
  tap_t    address;
  coef_t   coef_bits;
  sample_t buffer_bits;
  logic    pass_start;

  // Sticky dropped-sample flag and its clear
  logic    overrun;
  logic    overrun_clr;

  // Producer of samples/coefficients and consumer of the tap stream.
  modport master (
    output sample_in, sample_valid, coef_we, coef_waddr, coef_wdata, overrun_clr,
    input  sample_ready, address, coef_bits, buffer_bits, pass_start, overrun
  );

  // The sequencer itself.
  modport slave (
    input  sample_in, sample_valid, coef_we, coef_waddr, coef_wdata, overrun_clr,
    output sample_ready, address, coef_bits, buffer_bits, pass_start, overrun
  );

endinterface

// File: rtl/fir_delay_line.sv
// Circular ADC sample store. wp points at the newest committed sample; a
// commit writes at wp+1 and advances wp. Reads return x[wp - tap] one cycle
// later and see the memory contents from before any same-cycle write.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr_en,
  input  tap_t    clr_addr,
  input  logic    commit,
  input  sample_t commit_data,
  input  logic    rd_en,
  input  tap_t    tap,
  output sample_t rd_data
);

  sample_t mem [TAPS];
  tap_t    wp_reg;
  tap_t    wr_addr;
  tap_t    rd_addr;
  sample_t rd_data_reg;

  assign wr_addr = tap_inc(wp_reg);
  assign rd_addr = tap_sub(wp_reg, tap);
  assign rd_data = rd_data_reg;

  // Write pointer moves only when a staged sample is committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_reg <= '0;
    end else if (commit) begin
      wp_reg <= wr_addr;
    end
  end

  // Memory write: zero-fill during the clear sweep, otherwise commit the new sample.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (commit) begin
      mem[wr_addr] <= commit_data;
    end
  end

  // Registered read at the tap offset; holds zero until the first RUN read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: clears both memories after reset, then free-runs the tap
// index and presents address / coefficient / delayed sample to the MAC with
// one cycle of latency. New samples are staged through a valid/ready handshake
// and committed only at the last tap so each pass sees a stable window.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fir_tap_sequencer_if.slave bus
);

  state_t  state_reg;
  tap_t    cnt_reg;
  logic    pending_reg;
  sample_t staged_reg;
  logic    overrun_reg;
  tap_t    address_reg;
  coef_t   coef_bits_reg;
  logic    pass_start_reg;
  coef_t   coef_mem [TAPS];
  sample_t tap_sample;

  logic run;
  logic last_tap;
  logic ready;
  logic accept;
  logic drop;
  logic commit;

  assign run      = (state_reg == RUN);
  assign last_tap = (cnt_reg == tap_t'(TAPS - 1));
  assign ready    = run && !pending_reg;
  assign accept   = ready && bus.sample_valid;
  // Only a RUN-state offer while a sample is already staged is a drop; offers
  // during CLEAR are simply ignored.
  assign drop     = run && pending_reg && bus.sample_valid;
  // The staged sample lands at the pass boundary, when the last tap is read.
  assign commit   = run && pending_reg && last_tap;

  // One counter serves as the clear index in CLEAR and the tap index in RUN;
  // it wraps to 0 exactly as CLEAR hands over to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= tap_inc(cnt_reg);
      if (state_reg == CLEAR && last_tap) begin
        state_reg <= RUN;
      end
    end
  end

  // Single-entry staging register between the handshake and the delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
      staged_reg  <= '0;
    end else if (commit) begin
      pending_reg <= 1'b0;
    end else if (accept) begin
      pending_reg <= 1'b1;
      staged_reg  <= bus.sample_in;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_reg <= 1'b0;
    end
  end

  // Coefficient store write: zero-fill during CLEAR, host writes only in RUN.
  always_ff @(posedge clk) begin
    if (!run) begin
      coef_mem[cnt_reg] <= '0;
    end else if (bus.coef_we) begin
      coef_mem[bus.coef_waddr] <= bus.coef_wdata;
    end
  end

  // Registered tap outputs; a same-cycle coefficient write is not yet visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_reg    <= '0;
      coef_bits_reg  <= '0;
      pass_start_reg <= 1'b0;
    end else if (run) begin
      address_reg    <= cnt_reg;
      coef_bits_reg  <= coef_mem[cnt_reg];
      pass_start_reg <= (cnt_reg == '0);
    end
  end

  fir_delay_line u_delay_line (
    .clk         (clk),
    .reset       (reset),
    .clr_en      (!run),
    .clr_addr    (cnt_reg),
    .commit      (commit),
    .commit_data (staged_reg),
    .rd_en       (run),
    .tap         (cnt_reg),
    .rd_data     (tap_sample)
  );

  assign bus.sample_ready = ready;
  assign bus.address      = address_reg;
  assign bus.coef_bits    = coef_bits_reg;
  assign bus.buffer_bits  = tap_sample;
  assign bus.pass_start   = pass_start_reg;
  assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a queue-based reference model
// checked on every negative clock edge, plus hand-computed literal checks.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fir_tap_sequencer_if bus ();

  fir_tap_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[0] is the newest committed sample, hist[i] is x[n-i].
  sample_t hist[$];
  coef_t   coef_m [TAPS];
  int      clear_left;
  int      run_cycles;
  int      ph;
  bit      m_pending, was_pending, m_ovr;
  sample_t m_staged;
  tap_t    exp_addr;
  coef_t   exp_coef;
  sample_t exp_buf;
  bit      exp_ps;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_left = TAPS;
      run_cycles = 0;
      m_pending  = 1'b0;
      m_ovr      = 1'b0;
      m_staged   = '0;
      hist.delete();
      for (int i = 0; i < TAPS; i++) coef_m[i] = '0;
      exp_addr = '0;
      exp_coef = '0;
      exp_buf  = '0;
      exp_ps   = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      ph       = run_cycles % TAPS;
      exp_addr = tap_t'(ph);
      exp_coef = coef_m[ph];
      exp_buf  = (ph < hist.size()) ? hist[ph] : sample_t'(0);
      exp_ps   = (ph == 0);
      was_pending = m_pending;
      if (bus.sample_valid && !was_pending) begin
        m_pending = 1'b1;
        m_staged  = bus.sample_in;
      end
      if (bus.sample_valid && was_pending) m_ovr = 1'b1;
      else if (bus.overrun_clr) m_ovr = 1'b0;
      if (bus.coef_we) coef_m[bus.coef_waddr] = bus.coef_wdata;
      if (ph == TAPS - 1 && was_pending) begin
        hist.push_front(m_staged);
        if (hist.size() > TAPS) void'(hist.pop_back());
        m_pending = 1'b0;
      end
      run_cycles++;
    end
  end

  // Compare every output against the model whenever reset is released.
  always @(negedge clk) begin
    if (!reset) begin
      check("address", bus.address, exp_addr);
      check("coef_bits", bus.coef_bits, exp_coef);
      check("buffer_bits", bus.buffer_bits, exp_buf);
      check("pass_start", bus.pass_start, exp_ps);
      check("sample_ready", bus.sample_ready, (clear_left == 0) && !m_pending);
      check("overrun", bus.overrun, m_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_addr(input int a);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(bus.address) != a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (int'(bus.address) != a) begin
      total++;
      bad++;
      $display("FAIL wait_addr: got %0d expected %0d (timeout)", bus.address, a);
    end
  endtask

  task automatic send_sample(input sample_t s);
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  // Observes the 63 negedges of CLEAR that follow reset release, then the first RUN cycle.
  task automatic clear_phase();
    int viol;
    viol = 0;
    for (int i = 0; i < TAPS - 1; i++) begin
      @(negedge clk);
      if (bus.sample_ready || bus.address != '0) viol++;
    end
    check("clear_ready_addr_low", viol, 0);
    @(negedge clk);
    check("run_ready", bus.sample_ready, 1);
    check("run_first_addr", bus.address, 0);
  endtask

  // Watches one full pass starting at address 0 and offers sample s at address 10.
  task automatic run_pass(input sample_t s, output int pos, output int ones);
    wait_addr(0);
    ones = 0;
    pos  = -1;
    for (int i = 0; i < TAPS; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.buffer_bits == sample_t'(1)) begin
        ones++;
        pos = int'(bus.address);
      end
      if (i == 10) begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = s;
      end
      if (i == 11) bus.sample_valid = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pos, ones;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.coef_we      = 1'b0;
    bus.coef_waddr   = '0;
    bus.coef_wdata   = '0;
    bus.overrun_clr  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset then idle: CLEAR for 64 cycles, then the tap index runs.
    clear_phase();
    @(negedge clk);
    check("first_pass_addr", bus.address, 0);
    check("first_pass_start", bus.pass_start, 1);
    @(negedge clk);
    check("second_addr", bus.address, 1);
    check("second_pass_start", bus.pass_start, 0);
    wait_addr(63);
    @(negedge clk);
    check("wrap_addr", bus.address, 0);
    check("wrap_pass_start", bus.pass_start, 1);
    check("idle_buffer", bus.buffer_bits, 0);

    // Coefficient load and one sample mid-pass.
    bus.coef_we    = 1'b1;
    bus.coef_waddr = 6'd0;
    bus.coef_wdata = 16'sd1;
    @(negedge clk);
    bus.coef_waddr = 6'd5;
    bus.coef_wdata = -16'sd3;
    @(negedge clk);
    bus.coef_we = 1'b0;
    wait_addr(20);
    send_sample(12'sd100);
    wait_addr(0);
    check("sample100_buffer", bus.buffer_bits, 100);
    check("coef0", bus.coef_bits, 1);
    wait_addr(5);
    check("coef5", bus.coef_bits, -3);

    // Impulse walks one tap per pass and falls off after 64 passes.
    run_pass(12'sd1, pos, ones);
    for (int p = 0; p < 66; p++) begin
      run_pass(12'sd0, pos, ones);
      if (p < TAPS) begin
        check("impulse_ones", ones, 1);
        check("impulse_pos", pos, p);
      end else begin
        check("impulse_gone", ones, 0);
      end
    end

    // Overrun: back-to-back offers, clear, then set and clear together.
    wait_addr(20);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'sd7;
    @(negedge clk);
    check("ready_after_accept", bus.sample_ready, 0);
    bus.sample_in = 12'sd8;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("overrun_set", bus.overrun, 1);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check("overrun_cleared", bus.overrun, 0);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'sd9;
    bus.overrun_clr  = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.overrun_clr  = 1'b0;
    check("overrun_set_wins", bus.overrun, 1);
    wait_addr(0);
    check("first_of_pair_committed", bus.buffer_bits, 7);

    // Offer during the last-tap cycle: waits a full extra pass.
    wait_addr(62);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'sd55;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("late_ready_low", bus.sample_ready, 0);
    wait_addr(0);
    check("late_not_yet", bus.buffer_bits, 7);
    check("late_ready_still_low", bus.sample_ready, 0);
    wait_addr(0);
    check("late_visible", bus.buffer_bits, 55);
    check("late_ready_back", bus.sample_ready, 1);

    // Asynchronous reset mid-pass.
    wait_addr(30);
    #2 reset = 1'b1;
    #1;
    check("rst_address", bus.address, 0);
    check("rst_coef", bus.coef_bits, 0);
    check("rst_buffer", bus.buffer_bits, 0);
    check("rst_pass_start", bus.pass_start, 0);
    check("rst_ready", bus.sample_ready, 0);
    check("rst_overrun", bus.overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_phase();
    wait_addr(0);
    check("coef0_cleared", bus.coef_bits, 0);
    check("buffer_cleared", bus.buffer_bits, 0);
    wait_addr(5);
    check("coef5_cleared", bus.coef_bits, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Feeds the FIR multiply-accumulate stage. Drives its tap address, coefficient and delayed-sample inputs.
- Holds the ADC sample delay line and the loadable coefficient store.
- Free-runs the tap index 0..TAPS-1 so the MAC closes one output sample per pass; the MAC restarts its accumulation at address 0.
- New ADC samples enter through a valid/ready handshake and are committed only at a pass boundary, so every pass sees a consistent window.

Parameters:
- Order_MSB, 5, MSB of the tap address; TAPS = 2**(Order_MSB+1) = 64.
- Filter_MSB, 15, MSB of a signed coefficient.
- ADC_MSB, 11, MSB of a signed ADC sample.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  ADC_MSB+1  signed ADC sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_waddr  in  Order_MSB+1  coefficient index to write.
- coef_wdata  in  Filter_MSB+1  signed coefficient value.
- address  out  Order_MSB+1  tap index presented to the MAC.
- coef_bits  out  Filter_MSB+1  coef[address].
- buffer_bits  out  ADC_MSB+1  x[n-address], where n is the newest committed sample.
- pass_start  out  1  high in the cycle address==0 (RUN only).
- overrun  out  1  sticky: a sample was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async, immediate): address=0, coef_bits=0, buffer_bits=0, pass_start=0, sample_ready=0, overrun=0. Also tap counter=0, write pointer wp=0, pending=0, FSM=CLEAR.
- FSM CLEAR:
  - Clear counter steps 0..TAPS-1, one entry per cycle, writing 0 to delay line[i] and coef[i].
  - Outputs held at reset values; coef_we and sample_valid ignored.
  - After entry TAPS-1 is written, go to RUN with tap counter=0.
  - CLEAR lasts exactly TAPS cycles.
- FSM RUN:
  - Tap counter k increments every cycle and wraps TAPS-1 -> 0.
  - Memories are read at k and (wp-k) mod TAPS; the pointer wraps naturally at Order_MSB+1 bits.
  - Outputs are registered one cycle after the read: address=k, coef_bits=coef[k], buffer_bits=x[wp-k], pass_start=(k==0), all aligned in the same cycle.
  - Latency is 1 cycle from counter to outputs. After CLEAR, the first output cycle shows address=0.
- Handshake:
  - sample_ready = RUN && !pending.
  - sample_valid && sample_ready: stage sample_in, set pending.
  - sample_valid && !sample_ready in RUN: sample dropped, overrun set.
- Commit:
  - Occurs in the cycle k==TAPS-1 with pending set at the start of that cycle: delay line[wp+1] <= staged sample, wp <= wp+1, pending cleared.
  - That cycle's read of the same address (wp-(TAPS-1) = wp+1) returns the old value; reads are read-before-write.
  - A sample accepted during the k==TAPS-1 cycle waits for the next pass boundary.
- Coefficient write (RUN only):
  - coef[coef_waddr] <= coef_wdata.
  - A same-cycle read of that index returns the old value; the new value appears from the next read.
- overrun:
  - overrun_clr clears it.
  - A set event and overrun_clr in the same cycle leaves overrun=1 (set wins).
- Widths: no arithmetic on data; all data paths are width-preserving, and pointer arithmetic is modulo TAPS.
- Reset mid-operation: immediate return to reset values and CLEAR. Staged sample, coefficients and delay line are discarded (zeroed by CLEAR).

Decomposition:
- Package fir_pkg:
  - constants TAPS, ORDER_W, ADC_W, COEF_W;
  - typedefs sample_t, coef_t, tap_t;
  - enum state_t {CLEAR, RUN}.
- One sub-module, fir_delay_line: circular sample RAM with write pointer, commit port, read-before-write read at a tap offset.
- Coefficient store, FSM and handshake stay in the top level.

Test Plan:
- Reset then idle -> sample_ready=0 and address=0 for 64 cycles. Then address runs 0,1,...,63,0; pass_start pulses every 64 cycles; coef_bits=0 and buffer_bits=0 throughout.
- Load coef[0]=1, coef[5]=-3, send sample 100 mid-pass -> from the next pass on: address 0 shows buffer_bits=100, coef_bits=1; address 5 shows coef_bits=-3.
- Impulse: sample 1, then 0 on every later pass -> in pass p after commit, buffer_bits=1 only at address p (p=0..63); all zeros from pass 64 on.
- Two valid samples in consecutive mid-pass cycles -> first accepted, second dropped, overrun=1. overrun_clr -> 0. Set and clear in the same cycle -> stays 1.
- Sample valid exactly while address counter = 63 with pending clear -> accepted but not visible until the pass after next; sample_ready low until that commit.
- Assert reset while address=30 -> outputs 0 the same cycle (async), CLEAR repeats 64 cycles, previously loaded coefficients read back 0.
